// File: rtl/adder_pipe_if.sv
// adder_pipe_if: operand/result valid-ready bundle for adder_pipe.
// The slave modport is the adder's view; master is the source/sink side.
interface adder_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] SUM;
    logic             Cout;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Cin, sub, out_ready,
        input  in_ready, out_valid, SUM, Cout, Ovf
    );

    modport slave (
        input  in_valid, A, B, Cin, sub, out_ready,
        output in_ready, out_valid, SUM, Cout, Ovf
    );
endinterface

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined ripple-carry adder, one CHUNK-bit slice per stage,
// carry registered between stages, valid/ready with a single global advance.
// Optional feature macro: ADDER_PIPE_SUB_EN enables subtraction via the sub input.
// WIDTH must be a multiple of CHUNK, with 1 <= CHUNK <= WIDTH.
module adder_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4
) (
    input  logic        clk,
    input  logic        rst,
    adder_pipe_if.slave bus
);
    localparam int unsigned NSTAGE = WIDTH / CHUNK;
    localparam int unsigned CW     = CHUNK + 1;

    logic             adv_c;
    logic [WIDTH-1:0] b0;
    logic             cin0;

`ifdef ADDER_PIPE_SUB_EN
    // Subtract is folded in at entry: ~B with carry-in forced high; the
    // inverted operand then travels with the operation down the pipe.
    assign b0   = bus.sub ? ~bus.B : bus.B;
    assign cin0 = bus.sub | bus.Cin;
`else
    logic unused_sub;
    assign unused_sub = bus.sub;
    assign b0         = bus.B;
    assign cin0       = bus.Cin;
`endif

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        // IW: operand bits still unconsumed on entry; OW: sum bits known on exit.
        localparam int unsigned IW = WIDTH - k * CHUNK;
        localparam int unsigned OW = (k + 1) * CHUNK;

        logic             vld_d;
        logic [IW-1:0]    a_d;
        logic [IW-1:0]    b_d;
        logic             cin_d;
        logic [CHUNK-1:0] s_c;
        logic             co_c;
        logic [OW-1:0]    sum_d;
        logic             vld_q;
        logic             cy_q;
        logic [OW-1:0]    sum_q;

        if (k == 0) begin : g_head
            assign vld_d = bus.in_valid;
            assign a_d   = bus.A;
            assign b_d   = b0;
            assign cin_d = cin0;
            assign sum_d = s_c;
        end else begin : g_body
            assign vld_d = g_stage[k-1].vld_q;
            assign a_d   = g_stage[k-1].g_fwd.a_q;
            assign b_d   = g_stage[k-1].g_fwd.b_q;
            assign cin_d = g_stage[k-1].cy_q;
            assign sum_d = {s_c, g_stage[k-1].sum_q};
        end

        // Slice adder: lowest CHUNK unconsumed bits plus incoming carry.
        assign {co_c, s_c} = CW'(a_d[CHUNK-1:0]) + CW'(b_d[CHUNK-1:0]) + CW'(cin_d);

        // Stage register: valid, accumulated sum and carry out of this slice.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                sum_q <= '0;
            end else if (adv_c) begin
                vld_q <= vld_d;
                cy_q  <= co_c;
                sum_q <= sum_d;
            end
        end

        if (k < NSTAGE - 1) begin : g_fwd
            logic [IW-CHUNK-1:0] a_q;
            logic [IW-CHUNK-1:0] b_q;

            // Upper operand slices ride along with their operation.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv_c) begin
                    a_q <= a_d[IW-1:CHUNK];
                    b_q <= b_d[IW-1:CHUNK];
                end
            end
        end

        if (k == NSTAGE - 1) begin : g_tail
            logic msb_cin_c;
            logic ovf_q;

            // Carry into the MSB recovered from the MSB's sum and operand bits.
            assign msb_cin_c = s_c[CHUNK-1] ^ a_d[CHUNK-1] ^ b_d[CHUNK-1];

            // Signed overflow registered alongside the final sum and carry.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv_c) begin
                    ovf_q <= msb_cin_c ^ co_c;
                end
            end
        end
    end

    // Whole pipe moves together unless a finished result is being held.
    assign adv_c         = !bus.out_valid || bus.out_ready;
    assign bus.in_ready  = adv_c;
    assign bus.out_valid = g_stage[NSTAGE-1].vld_q;
    assign bus.SUM       = g_stage[NSTAGE-1].sum_q;
    assign bus.Cout      = g_stage[NSTAGE-1].cy_q;
    assign bus.Ovf       = g_stage[NSTAGE-1].g_tail.ovf_q;
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed checks of adder_pipe (WIDTH=8, CHUNK=4, latency 2).
module tb_adder_pipe;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CHUNK = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    adder_pipe_if #(.WIDTH(WIDTH)) bus ();

    adder_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] sa [10] = '{8'h12, 8'hF0, 8'h7F, 8'h80, 8'hAA, 8'h01, 8'hFF, 8'h39, 8'hC8, 8'h64};
    logic [7:0] sb [10] = '{8'h34, 8'h0F, 8'h7F, 8'h80, 8'h55, 8'hFF, 8'hFF, 8'h47, 8'h9C, 8'h64};
    logic       sc [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    logic [9:0] expq [$];
    int         sent;
    int         recv;
    int         cyc;
    logic       bv   [12];
    logic [9:0] bexp [12];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result packed as {ovf, cout, sum}.
    function automatic logic [9:0] ref_add(input logic [7:0] a, input logic [7:0] b,
                                           input logic cin, input logic sub);
        logic [7:0] bb;
        logic       c;
        logic [8:0] r;
        logic       ovf;
        logic       sub_en;
`ifdef ADDER_PIPE_SUB_EN
        sub_en = 1'b1;
`else
        sub_en = 1'b0;
`endif
        bb = b;
        c  = cin;
        if (sub && sub_en) begin
            bb = ~b;
            c  = 1'b1;
        end
        r   = {1'b0, a} + {1'b0, bb} + 9'(c);
        ovf = (a[7] == bb[7]) && (r[7] != a[7]);
        return {ovf, r};
    endfunction

    function automatic logic [9:0] obs();
        return {bus.Ovf, bus.Cout, bus.SUM};
    endfunction

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub);
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
        bus.Cin      = cin;
        bus.sub      = sub;
    endtask

    // One isolated operation; entered and left at #1 after a rising edge.
    task automatic single(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub, input logic [9:0] exp);
        bus.out_ready = 1'b1;
        drive(1'b1, a, b, cin, sub);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check({tag, "_lat"}, 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
        check(tag, 32'(obs()), 32'(exp));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus.out_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum",       32'(bus.SUM),       32'd0);
        check("rst_cout",      32'(bus.Cout),      32'd0);
        check("rst_ovf",       32'(bus.Ovf),       32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        // Directed single operations
        single("add_3c_15", 8'h3C, 8'h15, 1'b1, 1'b0, 10'h052);
        single("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 10'h280);
        single("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 10'h100);
        single("add_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 10'h300);
        single("add_ff_ff", 8'hFF, 8'hFF, 1'b1, 1'b0, 10'h1FF);
`ifdef ADDER_PIPE_SUB_EN
        single("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 10'h0FE);
`else
        single("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 10'h00C);
`endif

        // Back-to-back stream with a 3-cycle output stall
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 10 && cyc < 60) begin
            bus.out_ready = !(cyc >= 4 && cyc <= 6);
            if (sent < 10) drive(1'b1, sa[sent], sb[sent], sc[sent], 1'b0);
            else           drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
            #1;
            if (!bus.out_ready) begin
                check("stall_in_ready", 32'(bus.in_ready), 32'd0);
                check("stall_out_valid", 32'(bus.out_valid), 32'd1);
                if (expq.size() > 0) check("stall_hold", 32'(obs()), 32'(expq[0]));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    check("stream_unexpected", 32'(bus.out_valid), 32'd0);
                end else begin
                    check($sformatf("stream%0d", recv), 32'(obs()), 32'(expq.pop_front()));
                    recv++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back(ref_add(sa[sent], sb[sent], sc[sent], 1'b0));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("stream_count", 32'(recv), 32'd10);

        // Alternating bubbles
        bus.out_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            logic ev;
            ev = 1'b0;
            if (t >= 2) ev = bv[t-2];
            check($sformatf("bubble_vld%0d", t), 32'(bus.out_valid), 32'(ev));
            if (ev) check($sformatf("bubble_sum%0d", t), 32'(obs()), 32'(bexp[t-2]));
            bv[t]   = (t < 8) && (t % 2 == 0);
            bexp[t] = ref_add(8'(t * 17), 8'(t * 3 + 1), 1'b0, 1'b0);
            drive(bv[t], 8'(t * 17), 8'(t * 3 + 1), 1'b0, 1'b0);
            @(posedge clk); #1;
        end

        // Reset with two operations in flight
        drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 8'h40, 8'h02, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        check("pre_rst_vld", 32'(bus.out_valid), 32'd1);
        check("pre_rst_sum", 32'(bus.SUM), 32'h33);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_sum",       32'(bus.SUM),       32'd0);
        check("midrst_cout",      32'(bus.Cout),      32'd0);
        check("midrst_ovf",       32'(bus.Ovf),       32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        for (int t = 0; t < 4; t++) begin
            @(posedge clk); #1;
            check($sformatf("after_rst_vld%0d", t), 32'(bus.out_valid), 32'd0);
            check($sformatf("after_rst_rdy%0d", t), 32'(bus.in_ready), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined ripple-carry adder that is the multi-bit, clocked successor of the team's 1-bit and 2-bit full-adder blocks. It adds two WIDTH-bit operands plus a carry-in by splitting them into CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages. It accepts one operation per cycle through a valid/ready handshake. It produces the sum, carry-out and signed-overflow flag NSTAGE = WIDTH/CHUNK cycles later. It sits between operand registers and any datapath consumer that needs wide sums without a long combinational carry chain.

## Interface
Parameters:
- WIDTH, 8: operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4: bits added per pipeline stage; 1 ≤ CHUNK ≤ WIDTH.

Ports:
- clk  in  1: single clock; all state updates on the rising edge.
- rst  in  1: reset, asynchronous and active-high; clears all state immediately.
- in_valid  in  1: operand set on A/B/Cin/sub is valid.
- in_ready  out  1: block can accept an operand set this cycle.
- A  in  WIDTH: operand A, unsigned or two's complement.
- B  in  WIDTH: operand B.
- Cin  in  1: carry-in to bit 0.
- sub  in  1: subtract request; only honoured when ADDER_PIPE_SUB_EN is defined (see Configuration).
- out_valid  out  1: SUM/Cout/Ovf are valid.
- out_ready  in  1: consumer takes the result this cycle.
- SUM  out  WIDTH: result bits.
- Cout  out  1: carry out of bit WIDTH-1.
- Ovf  out  1: signed overflow; equals the carry into bit WIDTH-1 XOR Cout.

## Operation
- NSTAGE = WIDTH/CHUNK stages. Stage k (0..NSTAGE-1) adds bits [k·CHUNK +: CHUNK] of A and B plus the carry registered by stage k-1. Stage 0 uses Cin instead.
- Stage registers:
  - valid bit.
  - Partial sum bits already computed.
  - Carry.
  - Operand bits not yet consumed, so that upper slices travel with the operation.
- Carry-into-MSB is captured in the final stage for Ovf.
- Global advance: adv = !out_valid || out_ready.
  - When adv = 1, every stage loads from its predecessor and stage 0 loads the input.
  - When adv = 0, every stage holds, including valid bits.
- in_ready = adv, so an input is accepted on an edge only if in_valid && in_ready.
- If in_valid = 0 when adv = 1, a bubble (valid = 0) enters stage 0.
- Arithmetic is modulo 2^WIDTH. {Cout, SUM} = A + B + Cin exactly, as an unsigned (WIDTH+1)-bit value.
- No state machine beyond the per-stage valid shift; the block never drops, duplicates or reorders operations.
- Reset mid-operation: all in-flight operations are discarded and no result is emitted for them.

## Timing
- Reset values: out_valid = 0, SUM = 0, Cout = 0, Ovf = 0, all internal valid bits = 0. in_ready = 1 while and immediately after reset deasserts.
- Latency: an operand set accepted at edge n presents out_valid = 1 with its result after edge n+NSTAGE-1, visible in cycle n+NSTAGE. With NSTAGE = 1 the result is registered once, giving 1-cycle latency.
- Throughput: one operation per cycle while out_ready = 1.
- Backpressure:
  - out_valid = 1 with out_ready = 0 holds SUM, Cout and Ovf stable and deasserts in_ready in the same cycle. in_ready is combinational from out_ready and out_valid.
  - Results must remain unchanged until the handshake completes.
- Simultaneous accept and emit in the same cycle is legal and sustains full rate.
- in_valid with in_ready = 0: the input is not taken, and the source must hold it.

## Configuration
- ADDER_PIPE_SUB_EN defined: sub = 1 makes stage 0 use B' = ~B and force carry-in = 1, ignoring Cin, giving SUM = A − B. Cout = 1 means no borrow, and Ovf is signed overflow of the subtraction. The sub flag travels with the operation down the pipeline.
- ADDER_PIPE_SUB_EN undefined: the sub port exists but is ignored, and the block is a pure adder.

## Test plan
All scenarios use WIDTH = 8, CHUNK = 4, so latency is 2.
- Reset: assert rst mid-stream with two operations in flight → out_valid = 0 and SUM = 0 immediately. No result emerges after rst deasserts, and in_ready = 1.
- Single add: A = 0x3C, B = 0x15, Cin = 1 accepted at edge 0 → cycle 2 shows out_valid = 1, SUM = 0x52, Cout = 0, Ovf = 0.
- Inter-stage carry and overflow: A = 0x7F, B = 0x01, Cin = 0 → SUM = 0x80, Cout = 0, Ovf = 1. Then A = 0xFF, B = 0x01 → SUM = 0x00, Cout = 1, Ovf = 0.
- Streaming with backpressure:
  - Drive 10 back-to-back random operations and hold out_ready = 0 for 3 cycles mid-stream.
  - Required: in_ready = 0 during the stall, outputs stable throughout the stall, and all 10 results in order matching a reference {Cout, SUM}.
- Bubbles: alternate in_valid 1/0 → out_valid alternates 1/0 with 2-cycle lag and no spurious results.
- With ADDER_PIPE_SUB_EN: sub = 1, A = 0x05, B = 0x07 → SUM = 0xFE, Cout = 0. Without the macro, the same stimulus gives SUM = 0x0C.
